// File: rtl/bus_responder.sv
// Memory-side responder for the CPU bus: decodes IE, HRAM, boot overlay and the
// OAM DMA register, forwards everything else externally and runs the OAM DMA engine.
module bus_responder #(
  parameter int unsigned DMA_LEN   = 160,
  parameter logic [15:0] HRAM_BASE = 16'hFF80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  boot_addr,
  input  logic [7:0]  boot_rdata,
  output logic [15:0] ext_addr,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_we,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER
  } dma_state_t;

  dma_state_t r_state;
  dma_state_t w_state_nxt;

  logic [7:0] r_src;
  logic [7:0] r_idx;
  logic [7:0] r_ie;
  logic [7:0] r_dma_reg;
  logic       r_boot_en;
  logic [7:0] r_hram [128];

  logic       w_rd;
  logic       w_wr;
  logic       w_sel_ie;
  logic       w_sel_hram;
  logic       w_sel_boot_dis;
  logic       w_sel_dma;
  logic       w_sel_int;
  logic       w_sel_boot;
  logic       w_sel_ext;
  logic [6:0] w_hram_idx;
  logic       w_dma_wr;
  logic [7:0] w_src_fold;
  logic       w_last;
  logic       w_xfer;

  // A simultaneous read and write strobe is a write.
  assign w_rd = cpu_rd_en & ~cpu_wr_en;
  assign w_wr = cpu_wr_en;

  assign w_sel_ie       = (cpu_addr == 16'hFFFF);
  assign w_sel_hram     = !w_sel_ie && (cpu_addr >= HRAM_BASE);
  assign w_sel_boot_dis = (cpu_addr == 16'hFF50);
  assign w_sel_dma      = (cpu_addr == 16'hFF46);
  assign w_sel_int      = w_sel_ie | w_sel_hram | w_sel_boot_dis | w_sel_dma;
  assign w_sel_boot     = !w_sel_int && r_boot_en && (cpu_addr[15:8] == 8'h00);
  assign w_sel_ext      = !w_sel_int && !w_sel_boot;
  assign w_hram_idx     = 7'(cpu_addr - HRAM_BASE);

  assign w_dma_wr   = w_wr & w_sel_dma;
  // Sources in the echo-RAM range fold back onto work RAM.
  assign w_src_fold = (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;
  assign w_last     = (r_idx == 8'(DMA_LEN - 1));
  assign w_xfer     = (r_state == ST_XFER);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_IDLE;
      ST_SETUP: w_state_nxt = ST_XFER;
      ST_XFER:  if (w_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_dma_wr) w_state_nxt = ST_SETUP;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments to avoid update-order races.
    if (rst) begin
      r_state   <= ST_IDLE;
      r_src     <= 8'h00;
      r_idx     <= 8'h00;
      r_ie      <= 8'h00;
      r_dma_reg <= 8'hFF;
      r_boot_en <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_dma_wr) begin
        r_dma_reg <= cpu_wdata;
        r_src     <= w_src_fold;
        r_idx     <= 8'h00;
      end else if (w_xfer) begin
        r_idx <= w_last ? 8'h00 : r_idx + 8'h01;
      end
      if (w_wr && w_sel_ie) r_ie <= cpu_wdata;
      if (w_wr && w_sel_boot_dis && (cpu_wdata != 8'h00)) r_boot_en <= 1'b0;
    end
  end

  // NOTE: HRAM is a plain memory array with no reset so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (w_wr && w_sel_hram) r_hram[w_hram_idx] <= cpu_wdata;
  end

  always_comb begin
    cpu_rdata = 8'hFF;
    if (w_rd) begin
      if (w_sel_ie)            cpu_rdata = r_ie;
      else if (w_sel_hram)     cpu_rdata = r_hram[w_hram_idx];
      else if (w_sel_boot_dis) cpu_rdata = {7'h7F, ~r_boot_en};
      else if (w_sel_dma)      cpu_rdata = r_dma_reg;
      else if (dma_active)     cpu_rdata = 8'hFF;
      else if (w_sel_boot)     cpu_rdata = boot_rdata;
      else                     cpu_rdata = ext_rdata;
    end
  end

  // While DMA owns the port, CPU traffic outside internal space is dropped.
  assign dma_active = (r_state != ST_IDLE);
  assign ext_addr   = dma_active ? {r_src, r_idx} : cpu_addr;
  assign ext_rd     = w_xfer | (w_rd & w_sel_ext & ~dma_active);
  assign ext_wr     = w_wr & (w_sel_ext | w_sel_boot) & ~dma_active;
  assign ext_wdata  = cpu_wdata;
  assign boot_addr  = cpu_addr[7:0];
  assign oam_addr   = r_idx;
  assign oam_we     = w_xfer;
  assign oam_wdata  = ext_rdata;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: a behavioural memory-map model feeds
// read and OAM-write scoreboards that a negedge monitor drains.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rd_en = 1'b0;
  logic        cpu_wr_en = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic [7:0]  boot_addr;
  logic [7:0]  boot_rdata;
  logic [15:0] ext_addr;
  logic        ext_rd;
  logic        ext_wr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  bus_responder dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_rd_en  (cpu_rd_en),
    .cpu_wr_en  (cpu_wr_en),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .boot_addr  (boot_addr),
    .boot_rdata (boot_rdata),
    .ext_addr   (ext_addr),
    .ext_rd     (ext_rd),
    .ext_wr     (ext_wr),
    .ext_wdata  (ext_wdata),
    .ext_rdata  (ext_rdata),
    .oam_addr   (oam_addr),
    .oam_we     (oam_we),
    .oam_wdata  (oam_wdata),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  logic [7:0] ext_mem  [65536];
  logic [7:0] boot_rom [256];

  assign ext_rdata  = ext_mem[ext_addr];
  assign boot_rdata = boot_rom[boot_addr];

  typedef struct {
    logic [7:0]  idx;
    logic [7:0]  data;
    logic [15:0] addr;
  } oam_exp_t;

  oam_exp_t   oam_q[$];
  logic [7:0] rd_q[$];
  oam_exp_t   mon_oam;
  logic [7:0] mon_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] m_ie;
  logic [7:0] m_dma_reg;
  logic       m_boot_en;
  logic [7:0] m_hram [128];
  bit         dma_on;
  int         dma_cycle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
  endtask

  function automatic bit is_int(input logic [15:0] a);
    return (a == 16'hFFFF) || (a >= 16'hFF80) || (a == 16'hFF50) || (a == 16'hFF46);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    if (a == 16'hFFFF)                return m_ie;
    if (a >= 16'hFF80)                return m_hram[7'(a - 16'hFF80)];
    if (a == 16'hFF50)                return {7'h7F, ~m_boot_en};
    if (a == 16'hFF46)                return m_dma_reg;
    if (dma_on)                       return 8'hFF;
    if (a < 16'h0100 && m_boot_en)    return boot_rom[a[7:0]];
    return ext_mem[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (dma_on) begin
      dma_cycle++;
      if (dma_cycle > 161) dma_on = 0;
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    bit         exp_ext;
    logic [7:0] f;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr_en = 1'b1;
    cpu_rd_en = 1'b0;
    #1;
    exp_ext = !dma_on && !is_int(a);
    check("wr_ext_wr", ext_wr, exp_ext);
    check("wr_ext_rd", ext_rd, (dma_on && dma_cycle >= 2));
    if (exp_ext) begin
      check("wr_ext_addr", ext_addr, a);
      check("wr_ext_wdata", ext_wdata, d);
    end
    tick();
    cpu_wr_en = 1'b0;
    if (a == 16'hFFFF) m_ie = d;
    else if (a >= 16'hFF80) m_hram[7'(a - 16'hFF80)] = d;
    else if (a == 16'hFF50 && d != 8'h00) m_boot_en = 1'b0;
    else if (a == 16'hFF46) begin
      m_dma_reg = d;
      f = (d >= 8'd224) ? d - 8'd32 : d;
      oam_q.delete();
      for (int i = 0; i < 160; i++) begin
        logic [15:0] ea;
        ea = {f, 8'(i)};
        oam_q.push_back('{idx: 8'(i), data: ext_mem[ea], addr: ea});
      end
      dma_on    = 1;
      dma_cycle = 1;
    end
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    rd_q.push_back(exp_rd(a));
    cpu_addr  = a;
    cpu_rd_en = 1'b1;
    cpu_wr_en = 1'b0;
    #1;
    if (dma_on) begin
      check("rd_ext_rd_dma", ext_rd, (dma_cycle >= 2));
    end else begin
      check("rd_ext_rd", ext_rd, (!is_int(a) && !(a < 16'h0100 && m_boot_en)));
      if (!is_int(a)) check("rd_ext_addr", ext_addr, a);
    end
    check("rd_ext_wr", ext_wr, 1'b0);
    tick();
    cpu_rd_en = 1'b0;
  endtask

  task automatic wait_dma_done();
    while (dma_on && dma_cycle < 161) tick();
    check("dma_active_last", dma_active, 1'b1);
    check("oam_we_last", oam_we, 1'b1);
    tick();
    check("dma_active_done", dma_active, 1'b0);
    check("oam_we_done", oam_we, 1'b0);
    check("oam_pending", oam_q.size(), 0);
  endtask

  // Monitor: drains the scoreboards whenever the DUT presents a read or an OAM write.
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_rd_en && !cpu_wr_en) begin
        if (rd_q.size() == 0) fail("cpu_read");
        else begin
          mon_rd = rd_q.pop_front();
          check("cpu_rdata", cpu_rdata, mon_rd);
        end
      end
      if (oam_we) begin
        if (oam_q.size() == 0) fail("oam_we");
        else begin
          mon_oam = oam_q.pop_front();
          check("oam_addr", oam_addr, mon_oam.idx);
          check("oam_wdata", oam_wdata, mon_oam.data);
          check("dma_ext_addr", ext_addr, mon_oam.addr);
          check("dma_ext_rd", ext_rd, 1'b1);
        end
      end
    end
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    for (int i = 0; i < 65536; i++) ext_mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      boot_rom[i] = 8'($urandom);
      ext_mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
    end
    boot_rom[0] = 8'h31;
    ext_mem[0]  = 8'hC3;
    m_ie = 8'h00; m_dma_reg = 8'hFF; m_boot_en = 1'b1;
    dma_on = 0; dma_cycle = 0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_dma_active", dma_active, 1'b0);
    check("rst_ext_rd", ext_rd, 1'b0);
    check("rst_ext_wr", ext_wr, 1'b0);
    check("rst_oam_we", oam_we, 1'b0);
    check("rst_oam_addr", oam_addr, 8'h00);
    check("rst_idle_rdata", cpu_rdata, 8'hFF);
    cpu_rd(16'hFF46);
    cpu_rd(16'hFFFF);
    cpu_rd(16'hFF50);

    // Boot overlay, pass-through write, and the disable latch.
    cpu_rd(16'h0000);
    cpu_wr(16'h0010, 8'h5E);
    cpu_wr(16'hFF50, 8'h01);
    cpu_rd(16'h0000);
    cpu_rd(16'hFF50);
    cpu_wr(16'hFF50, 8'h00);
    cpu_rd(16'h0000);

    cpu_wr(16'hFF80, 8'hA5);
    cpu_rd(16'hFF80);
    cpu_wr(16'hFFFF, 8'h1F);
    cpu_rd(16'hFFFF);

    for (int k = 0; k < 16; k++) begin
      a = 16'hFF80 + 16'($urandom_range(0, 126));
      d = 8'($urandom);
      cpu_wr(a, d);
      cpu_rd(a);
    end
    for (int k = 0; k < 12; k++) begin
      a = 16'($urandom_range(0, 16'hFEFF));
      cpu_rd(a);
      cpu_wr(a, 8'($urandom));
    end

    // Simultaneous strobes act as a write.
    cpu_addr = 16'h8000; cpu_wdata = 8'h3C; cpu_rd_en = 1'b1; cpu_wr_en = 1'b1;
    #1;
    check("both_ext_wr", ext_wr, 1'b1);
    check("both_ext_rd", ext_rd, 1'b0);
    check("both_rdata", cpu_rdata, 8'hFF);
    check("both_ext_addr", ext_addr, 16'h8000);
    tick();
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;

    // DMA from C100 with CPU traffic interleaved.
    cpu_wr(16'hFF46, 8'hC1);
    check("setup_dma_active", dma_active, 1'b1);
    check("setup_oam_we", oam_we, 1'b0);
    cpu_rd(16'hC000);
    cpu_wr(16'hC000, 8'h12);
    cpu_wr(16'hFF90, 8'h77);
    cpu_rd(16'hFF90);
    cpu_rd(16'hFF46);
    cpu_rd(16'h0000);
    wait_dma_done();

    // Echo fold and restart mid-transfer.
    cpu_wr(16'hFF46, 8'hE2);
    while (dma_cycle < 52) tick();
    cpu_wr(16'hFF46, 8'h80);
    check("restart_dma_active", dma_active, 1'b1);
    check("restart_oam_we", oam_we, 1'b0);
    check("restart_ext_rd", ext_rd, 1'b0);
    cpu_rd(16'hFF46);
    wait_dma_done();

    cpu_wr(16'hFF46, 8'($urandom));
    wait_dma_done();

    // Reset during byte 10 of a transfer.
    cpu_wr(16'hFF46, 8'($urandom));
    while (dma_cycle < 12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    oam_q.delete();
    dma_on = 0;
    m_ie = 8'h00; m_dma_reg = 8'hFF; m_boot_en = 1'b1;
    check("rstdma_dma_active", dma_active, 1'b0);
    check("rstdma_oam_we", oam_we, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rstdma_quiet", oam_we, 1'b0);
    end
    cpu_rd(16'hFF46);
    cpu_rd(16'h0000);
    cpu_rd(16'hFFFF);

    tick();
    check("rd_q_empty", rd_q.size(), 0);
    check("oam_q_empty", oam_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the CPU's single-cycle bus (`rd_en`/`wr_en`/`addr`/`data`). It decodes every CPU access and serves the following regions:

- Internal HRAM and the IE register.
- The boot-ROM overlay and its disable latch.
- The OAM DMA register.

All other addresses are forwarded to an external memory port. It also contains the OAM DMA engine, which owns the external port for 161 cycles after a write to FF46 and blocks CPU access to non-internal space while active.

## Interface
Parameters:
- `DMA_LEN`, 160: bytes per OAM DMA transfer.
- `HRAM_BASE`, 16'hFF80: first HRAM address; HRAM spans FF80–FFFE (127 bytes).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_rd_en` in 1: CPU read strobe (instruction fetch or data read).
- `cpu_wr_en` in 1: CPU write strobe.
- `cpu_addr` in 16: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: read data, combinational from `cpu_addr` in the same cycle.
- `boot_addr` out 8: boot ROM address, equal to `cpu_addr[7:0]`.
- `boot_rdata` in 8: boot ROM data, asynchronous.
- `ext_addr` out 16: external memory address.
- `ext_rd` out 1: external read strobe.
- `ext_wr` out 1: external write strobe.
- `ext_wdata` out 8: external write data.
- `ext_rdata` in 8: external read data, asynchronous (valid in the same cycle).
- `oam_addr` out 8: OAM write index.
- `oam_we` out 1: OAM write enable.
- `oam_wdata` out 8: OAM write data.
- `dma_active` out 1: DMA engine owns the external port.

## Operation
Decode priority, highest first:
- FFFF: IE register, 8 bits.
- FF80–FFFE: HRAM.
- FF50: boot disable.
- FF46: DMA source register.
- 0000–00FF while `boot_en` = 1: boot ROM.
- Everything else: external port.

Access rules:
- Read (`cpu_rd_en` = 1, `cpu_wr_en` = 0):
  - `cpu_rdata` comes from the decoded region, combinationally.
  - FF46 reads return the last written source value.
  - FF50 reads return `{7'h7F, ~boot_en}`.
- Idle: with no strobe, `cpu_rdata` = 8'hFF.
- Write: commits on the rising edge where `cpu_wr_en` = 1.
  - Boot-ROM-mapped writes pass through to the external port; ROM is never written.
  - Writing a nonzero value to FF50 clears `boot_en` until the next reset.
  - Writing zero to FF50 has no effect.
- Simultaneous `cpu_rd_en` and `cpu_wr_en`:
  - Treated as a write.
  - `cpu_rdata` = 8'hFF.
- External pass-through (DMA idle):
  - `ext_addr` = `cpu_addr`, `ext_rd` = `cpu_rd_en` & ~`cpu_wr_en`, `ext_wr` = `cpu_wr_en`, `ext_wdata` = `cpu_wdata`.
  - These apply only for externally decoded addresses; the strobes are 0 otherwise.

DMA FSM (states IDLE, SETUP, XFER):
- IDLE → SETUP: on a CPU write to FF46. Latch `src` = `cpu_wdata`, clear `idx`.
  - If `src` ≥ 8'hE0, use `src` − 8'h20 (echo-RAM fold).
- SETUP → XFER: after one cycle. No transfer happens in SETUP.
- XFER, each cycle:
  - `ext_addr` = `{src, idx}`, `ext_rd` = 1.
  - `oam_addr` = `idx`, `oam_wdata` = `ext_rdata`, `oam_we` = 1.
  - `idx` increments.
- XFER → IDLE: after the `idx` = `DMA_LEN`−1 cycle.
- Any state → SETUP: a CPU write to FF46 restarts the transfer with the new `src` and `idx` = 0. The write of a value equal to the current source still restarts.

CPU access while `dma_active` = 1:
- IE, HRAM, FF46 and FF50 behave normally.
- All other reads return 8'hFF.
- All other writes are dropped; no `ext_wr` is issued.

## Timing
- Reset values:
  - Outputs: `dma_active` 0, `ext_rd` 0, `ext_wr` 0, `oam_we` 0, `oam_addr` 0.
  - `cpu_rdata` 8'hFF when idle.
  - Internal state: `boot_en` 1, IE 8'h00, FF46 8'hFF, FSM IDLE, `idx` 0.
  - HRAM contents are not reset.
- Read latency is 0 cycles: a combinational path from `cpu_addr` to `cpu_rdata`, sampled by the CPU at the same edge.
- Write latency: a value written at edge N is readable in cycle N+1.
- DMA cycle schedule, with the FF46 write committing at edge N:
  - `dma_active` rises in cycle N+1 (SETUP).
  - Bytes 0..159 transfer in cycles N+2..N+161.
  - `dma_active` is 0 in cycle N+162.
  - Total busy time is 161 cycles.
- OAM writes: `oam_we` is registered-state driven, and OAM commits on the clock edge ending each XFER cycle.
- `rst` asserted mid-DMA:
  - The FSM returns to IDLE at that edge.
  - `oam_we` = 0 in the following cycle.
  - No further OAM writes occur.
- `idx` is 8-bit, compared against `DMA_LEN`−1, and never wraps past 159.

## Test plan
- Reset, then a read of 0x0000 with `boot_rdata` = 8'h31 → `cpu_rdata` = 8'h31 and `ext_rd` = 0. Write 8'h01 to FF50, then read 0x0000 with `ext_rdata` = 8'hC3 → `cpu_rdata` = 8'hC3. A later write of 8'h00 to FF50 leaves the overlay off.
- Write 8'hA5 to FF80 and 8'h1F to FFFF → the next-cycle reads return 8'hA5 and 8'h1F, with no external strobes. Reading FF46 after reset → 8'hFF.
- Write 8'hC1 to FF46 with external memory byte at address `C100+i` = `i^8'h5A` → cycle N+1 has `dma_active` = 1 and `oam_we` = 0. Cycles N+2..N+161 show `oam_addr` = `i` and `oam_wdata` = `i^8'h5A`. `dma_active` = 0 at N+162.
- During the DMA: a CPU read of C000 → 8'hFF and no `ext_rd` change; a write to C000 → no `ext_wr`; a write/read of FF90 → works normally.
- Write 8'hE2 to FF46 → `ext_addr` = C200 on the first XFER cycle. Rewrite FF46 = 8'h80 at byte 50 → one SETUP cycle, then the transfer restarts at `oam_addr` 0 from `ext_addr` 8000.
- Assert `rst` at byte 10 of a DMA → `dma_active` = 0 and `oam_we` = 0 from the next cycle. Simultaneous `rd_en` and `wr_en` to 8000 → `ext_wr` = 1, `ext_rd` = 0, `cpu_rdata` = 8'hFF.
